// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Free-running pixel/line counters, sync and display-enable strobes derived
// from them, and a per-signal shift register that delays hs/vs/blank by
// PIPE_DLY cycles so they line up with a downstream renderer's latency.
// DrawX/DrawY, frame_start and frame_count are not delayed.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic x_wrap;
  logic y_wrap;
  logic frame_wrap;
  logic hs_raw;
  logic vs_raw;
  logic blank_raw;

  assign x_wrap     = (DrawX == H_LAST);
  assign y_wrap     = (DrawY == V_LAST);
  assign frame_wrap = x_wrap & y_wrap;

  // Pixel and line counters; the line advances only when the pixel count wraps.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX <= '0;
      DrawY <= '0;
    end else begin
      if (x_wrap) begin
        DrawX <= '0;
        DrawY <= y_wrap ? 10'd0 : DrawY + 10'd1;
      end else begin
        DrawX <= DrawX + 10'd1;
      end
    end
  end

  // Frame marker is registered on the wrap edge, so the reset-held (0,0)
  // state never produces a pulse; the frame counter advances on that same edge.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Undelayed strobes decoded from the current counter state.
  always_comb begin
    hs_raw    = ~((DrawX >= HS_START) && (DrawX < HS_END));
    vs_raw    = ~((DrawY >= VS_START) && (DrawY < VS_END));
    blank_raw = (DrawX < H_VIS) && (DrawY < V_VIS);
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      // Without delay stages, reset must still force the idle levels directly.
      assign hs    = hs_raw | reset;
      assign vs    = vs_raw | reset;
      assign blank = blank_raw & ~reset;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe;
      logic [PIPE_DLY-1:0] vs_pipe;
      logic [PIPE_DLY-1:0] blank_pipe;

      // Delay line per strobe; reset flushes in-flight contents to idle levels.
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe    <= '1;
          vs_pipe    <= '1;
          blank_pipe <= '0;
        end else begin
          hs_pipe[0]    <= hs_raw;
          vs_pipe[0]    <= vs_raw;
          blank_pipe[0] <= blank_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe[i]    <= hs_pipe[i-1];
            vs_pipe[i]    <= vs_pipe[i-1];
            blank_pipe[i] <= blank_pipe[i-1];
          end
        end
      end

      assign hs    = hs_pipe[PIPE_DLY-1];
      assign vs    = vs_pipe[PIPE_DLY-1];
      assign blank = blank_pipe[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 Parameter PIPE_DLY, 2, cycles of delay applied to hs, vs and blank (range 0..4) to match downstream renderer latency.
REQ-006 vga_clk  input  1  pixel clock; the only clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 DrawX  output  10  current horizontal count (pixel column).
REQ-009 DrawY  output  10  current vertical count (line).
REQ-010 hs  output  1  horizontal sync, active-low, delayed PIPE_DLY cycles.
REQ-011 vs  output  1  vertical sync, active-low, delayed PIPE_DLY cycles.
REQ-012 blank  output  1  display enable, 1 = visible pixel, delayed PIPE_DLY cycles.
REQ-013 frame_start  output  1  one-cycle pulse, undelayed, when DrawX=0 and DrawY=0.
REQ-014 frame_count  output  8  frames completed since reset, wraps 255->0.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-016 DrawX increments by 1 every vga_clk; at H_TOTAL-1 it wraps to 0 on the next edge.
REQ-017 DrawY increments by 1 only on the edge where DrawX wraps; at V_TOTAL-1 with DrawX=H_TOTAL-1 it wraps to 0.
REQ-018 DrawX and DrawY are registered counter outputs; no combinational path from any input.
REQ-019 Undelayed hs_raw = 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-020 Undelayed vs_raw = 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-021 Undelayed blank_raw = 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-022 hs, vs, blank equal hs_raw, vs_raw, blank_raw for the counter state PIPE_DLY cycles earlier, via a PIPE_DLY-stage shift register per signal; PIPE_DLY=0 drives them directly from the counter registers.
REQ-023 frame_start = 1 for exactly the cycle in which DrawX=0 and DrawY=0, excluding the reset-held state (first pulse after reset release occurs only after a full frame, on the wrap).
REQ-024 frame_count increments by 1 on the edge where both counters wrap to (0,0); 8-bit modular.
REQ-025 Counter widths: 10 bits; parameter values giving H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-026 While reset=1, asynchronously: DrawX=0, DrawY=0, frame_count=0, frame_start=0, all delay stages and outputs hs=1, vs=1, blank=0.
REQ-027 First edge after reset deassertion: DrawX becomes 1; counting then proceeds per REQ-016/017.
REQ-028 Reset asserted mid-frame/mid-sync forces REQ-026 values immediately with no clock edge, discarding in-flight delay-stage contents.

Verification
REQ-029 Release reset, run 800 cycles -> DrawX sequence 0..799 then 0, DrawY steps 0->1 at the wrap; hs low for exactly 96 cycles, first low 2 cycles after DrawX=656 (PIPE_DLY=2).
REQ-030 Run one full frame (420000 cycles) -> vs low for exactly 1600 cycles starting at DrawY=490 (plus 2-cycle delay); frame_start pulses once, frame_count 0->1.
REQ-031 Count blank=1 cycles over one frame -> exactly 307200; blank rises 2 cycles after DrawX=0 of DrawY=0 and falls 2 cycles after DrawX=640.
REQ-032 Run 256 frames -> frame_count wraps 255->0; frame_start pulse count = 256.
REQ-033 Assert reset asynchronously at DrawX=700, DrawY=490 (hs and vs low) -> hs=1, vs=1, blank=0, DrawX=0, DrawY=0 before next vga_clk edge; normal sequence resumes after release.
REQ-034 Rebuild with PIPE_DLY=0 -> hs falls on the same cycle DrawX=656; all other checks hold with zero offset.
